// File: rtl/uart_tx_serializer.sv
// Word-to-byte serializer that feeds a UART. Input words are queued in a small FIFO.
// Each word is shifted out one byte at a time using a valid/accept handshake.
module uart_tx_serializer #(
  parameter int unsigned WORD_BYTES = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MSB_FIRST  = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [8*WORD_BYTES-1:0]           input_dato,
  input  logic                              next_uart,
  output logic [7:0]                        Output_dato,
  output logic                              flat_out,
  output logic                              busy,
  output logic                              full,
  output logic                              overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   words_pending
);

  localparam int unsigned W  = 8 * WORD_BYTES;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      out_q, out_d;
  logic            flat_q, flat_d;
  logic            busy_q, busy_d;
  logic            overflow_q, overflow_d;
  logic            accept, last, pop, push;

  function automatic logic [7:0] head_byte(input logic [W-1:0] w);
    if (MSB_FIRST != 0) return w[W-1 -: 8];
    else                return w[7:0];
  endfunction

  function automatic logic [W-1:0] advance(input logic [W-1:0] w);
    if (MSB_FIRST != 0) return w << 8;
    else                return w >> 8;
  endfunction

  assign full = (count_q == CW'(FIFO_DEPTH));

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    out_d      = out_q;
    flat_d     = flat_q;
    accept     = (state_q == SEND) && next_uart;
    last       = (idx_q == 3'(WORD_BYTES - 1));
    // A pop happens from IDLE, or on the final accepted byte so words chain with no gap.
    pop        = (count_q != '0) && ((state_q == IDLE) || (accept && last));
    push       = start && (!full || pop);
    overflow_d = overflow_q | (start && full && !pop);
    count_d    = count_q + CW'(push) - CW'(pop);
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);

    if (pop) begin
      shift_d = mem_q[rd_ptr_q];
      idx_d   = '0;
      out_d   = head_byte(mem_q[rd_ptr_q]);
      flat_d  = 1'b1;
      state_d = SEND;
    end else if (accept) begin
      if (last) begin
        idx_d   = '0;
        flat_d  = 1'b0;
        state_d = IDLE;
      end else begin
        shift_d = advance(shift_q);
        idx_d   = idx_q + 3'd1;
        out_d   = head_byte(advance(shift_q));
      end
    end

    busy_d = flat_d || (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      shift_q    <= '0;
      idx_q      <= '0;
      out_q      <= '0;
      flat_q     <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      out_q      <= out_d;
      flat_q     <= flat_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is left unreset; reset clears the pointers and count, so stale entries are unreachable.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= input_dato;
  end

  assign Output_dato   = out_q;
  assign flat_out      = flat_q;
  assign busy          = busy_q;
  assign overflow      = overflow_q;
  assign words_pending = count_q;

endmodule
